// File: rtl/enemy_sprite_engine.sv
// Enemy sprite lookup stage: frame-latched state, walk animation, 3-cycle ROM pipeline.
// Optional hit flash enabled by defining ENEMY_HIT_FLASH_EN.
module enemy_sprite_engine #(
  parameter int ENEMY_NUM    = 4,
  parameter int SPR_W        = 32,
  parameter int SPR_H        = 32,
  parameter int ANIM_FRAMES  = 4,
  parameter int ANIM_DIV     = 8,
  parameter int FLASH_FRAMES = 6,
  localparam int CW = $clog2(SPR_W),
  localparam int RW = $clog2(SPR_H),
  localparam int FW = $clog2(ANIM_FRAMES),
  localparam int DW = $clog2(ANIM_DIV),
  localparam int AW = 2 + FW + RW + CW
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_start,
  input  logic                           pix_valid,
  input  logic [9:0]                     DrawX,
  input  logic [9:0]                     DrawY,
  input  logic [ENEMY_NUM-1:0]           enemy_alive,
  input  logic [ENEMY_NUM-1:0][9:0]      enemy_x,
  input  logic [ENEMY_NUM-1:0][9:0]      enemy_y,
  input  logic [ENEMY_NUM-1:0][1:0]      enemy_dir,
  input  logic [ENEMY_NUM-1:0]           enemy_moving,
  input  logic [ENEMY_NUM-1:0]           enemy_hit,
  output logic [ENEMY_NUM-1:0][AW-1:0]   spr_rom_addr,
  input  logic [ENEMY_NUM-1:0][4:0]      spr_rom_data,
  output logic                           out_valid,
  output logic [ENEMY_NUM-1:0]           is_enemy,
  output logic [ENEMY_NUM-1:0][4:0]      enemy_index
);

  logic [ENEMY_NUM-1:0]         alive_q;
  logic [ENEMY_NUM-1:0][9:0]    x_q, y_q;
  logic [ENEMY_NUM-1:0][1:0]    dir_q;
  logic [ENEMY_NUM-1:0][DW-1:0] div_q;
  logic [ENEMY_NUM-1:0][FW-1:0] anim_q;

  logic [ENEMY_NUM-1:0]         in0_q, in1_q;
  logic                         v0_q, v1_q;
  logic [ENEMY_NUM-1:0]         in_d;
  logic [ENEMY_NUM-1:0][AW-1:0] addr_d;
  logic [ENEMY_NUM-1:0][9:0]    col_w, row_w;
  logic [ENEMY_NUM-1:0][4:0]    idx_d;
  logic [ENEMY_NUM-1:0]         flash1_q;

  // Shadow copy of enemy state, refreshed only at frame start
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      alive_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= '0;
    end else if (frame_start) begin
      alive_q <= enemy_alive;
      x_q     <= enemy_x;
      y_q     <= enemy_y;
      dir_q   <= enemy_dir;
    end
  end

  // Walk animation: divide frame pulses, step frame while moving
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q  <= '0;
      anim_q <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < ENEMY_NUM; i++) begin
        if (!alive_q[i] || !enemy_moving[i]) begin
          div_q[i]  <= '0;
          anim_q[i] <= '0;
        end else if (div_q[i] == DW'(ANIM_DIV - 1)) begin
          div_q[i]  <= '0;
          anim_q[i] <= anim_q[i] + 1'b1;
        end else begin
          div_q[i] <= div_q[i] + 1'b1;
        end
      end
    end
  end

  // Box test in 11 bits so x+SPR_W cannot wrap; build ROM address
  always_comb begin
    in_d   = '0;
    addr_d = '0;
    col_w  = '0;
    row_w  = '0;
    for (int i = 0; i < ENEMY_NUM; i++) begin
      col_w[i] = DrawX - x_q[i];
      row_w[i] = DrawY - y_q[i];
      in_d[i]  = pix_valid & alive_q[i]
               & ({1'b0, DrawX} >= {1'b0, x_q[i]})
               & ({1'b0, DrawX} <  {1'b0, x_q[i]} + 11'(SPR_W))
               & ({1'b0, DrawY} >= {1'b0, y_q[i]})
               & ({1'b0, DrawY} <  {1'b0, y_q[i]} + 11'(SPR_H));
      if (in_d[i])
        addr_d[i] = {dir_q[i], anim_q[i],
                     row_w[i][RW-1:0], col_w[i][CW-1:0]};
    end
  end

  // E0/E1 pipeline registers; ROM sits between E1 and E2
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      spr_rom_addr <= '0;
      in0_q        <= '0;
      v0_q         <= 1'b0;
      in1_q        <= '0;
      v1_q         <= 1'b0;
    end else begin
      spr_rom_addr <= addr_d;
      in0_q        <= in_d;
      v0_q         <= pix_valid;
      in1_q        <= in0_q;
      v1_q         <= v0_q;
    end
  end

`ifdef ENEMY_HIT_FLASH_EN
  localparam int FCW = $clog2(FLASH_FRAMES + 1);
  logic [ENEMY_NUM-1:0][FCW-1:0] flash_q;
  logic [ENEMY_NUM-1:0]          flash0_q;

  // Flash countdown; a hit reloads and beats a same-edge decrement
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flash_q <= '0;
    end else begin
      for (int i = 0; i < ENEMY_NUM; i++) begin
        if (enemy_hit[i])
          flash_q[i] <= FCW'(FLASH_FRAMES);
        else if (frame_start && flash_q[i] != '0)
          flash_q[i] <= flash_q[i] - 1'b1;
      end
    end
  end

  // Flash state travels with the pixel it was sampled for
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flash0_q <= '0;
      flash1_q <= '0;
    end else begin
      for (int i = 0; i < ENEMY_NUM; i++)
        flash0_q[i] <= (flash_q[i] != '0);
      flash1_q <= flash0_q;
    end
  end
`else
  logic unused_hit;
  assign unused_hit = ^enemy_hit;
  assign flash1_q   = '0;
`endif

  // Mask ROM data outside the box; flashing slots show white
  always_comb begin
    idx_d = '0;
    for (int i = 0; i < ENEMY_NUM; i++) begin
      if (in1_q[i])
        idx_d[i] = spr_rom_data[i];
      if (flash1_q[i] && idx_d[i] != 5'd0)
        idx_d[i] = 5'd2;
    end
  end

  // E2 output register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid   <= 1'b0;
      is_enemy    <= '0;
      enemy_index <= '0;
    end else begin
      out_valid   <= v1_q;
      is_enemy    <= in1_q;
      enemy_index <= idx_d;
    end
  end

endmodule

// File: tb/tb_enemy_sprite_engine.sv
// Directed bench for enemy_sprite_engine.
// Hit-flash checks are built when ENEMY_HIT_FLASH_EN is defined.
module tb_enemy_sprite_engine;
  localparam int N = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_start = 1'b0;
  logic pix_valid = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [N-1:0] enemy_alive = '0;
  logic [N-1:0] enemy_moving = '0;
  logic [N-1:0] enemy_hit = '0;
  logic [N-1:0][9:0] enemy_x = '0;
  logic [N-1:0][9:0] enemy_y = '0;
  logic [N-1:0][1:0] enemy_dir = '0;
  logic [N-1:0][13:0] spr_rom_addr;
  logic [N-1:0][4:0] spr_rom_data = '0;
  logic [N-1:0][4:0] enemy_index;
  logic [N-1:0] is_enemy;
  logic out_valid;

  int nvec = 0;
  int nmis = 0;

  always #5 Clk = ~Clk;

  enemy_sprite_engine dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY),
    .enemy_alive(enemy_alive), .enemy_x(enemy_x),
    .enemy_y(enemy_y), .enemy_dir(enemy_dir),
    .enemy_moving(enemy_moving), .enemy_hit(enemy_hit),
    .spr_rom_addr(spr_rom_addr),
    .spr_rom_data(spr_rom_data),
    .out_valid(out_valid), .is_enemy(is_enemy),
    .enemy_index(enemy_index)
  );

  // Synchronous ROM model: palette = row ^ col
  always @(posedge Clk)
    for (int i = 0; i < N; i++)
      spr_rom_data[i] <= spr_rom_addr[i][4:0] ^ spr_rom_addr[i][9:5];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic fs;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
  endtask

  task automatic probe(input int x, input int y,
                       output int a0, output int a1,
                       output int ie, output int i0,
                       output int i1, output int ov);
    DrawX = 10'(x);
    DrawY = 10'(y);
    pix_valid = 1'b1;
    tick;
    a0 = int'(spr_rom_addr[0]);
    a1 = int'(spr_rom_addr[1]);
    chk("ov_after_e0", int'(out_valid), 0);
    pix_valid = 1'b0;
    tick;
    chk("ov_after_e1", int'(out_valid), 0);
    tick;
    ie = int'(is_enemy);
    i0 = int'(enemy_index[0]);
    i1 = int'(enemy_index[1]);
    ov = int'(out_valid);
  endtask

  typedef struct {
    logic al;
    int x, y, dir, dx, dy;
    int ie, addr, idx;
  } vec_t;

  vec_t v[11];
  int a0, a1, ie, i0, i1, ov;

  initial begin
    v[0]  = '{1'b1, 100, 50, 3, 105, 52, 1, 12357, 7};
    v[1]  = '{1'b1, 620, 50, 0, 639, 60, 1, 339, 25};
    v[2]  = '{1'b1, 100, 50, 2, 100, 50, 1, 8192, 0};
    v[3]  = '{1'b1, 100, 50, 2, 132, 50, 0, 0, 0};
    v[4]  = '{1'b1, 100, 50, 2, 131, 80, 1, 9183, 1};
    v[5]  = '{1'b1, 100, 50, 2, 99, 50, 0, 0, 0};
    v[6]  = '{1'b1, 100, 50, 2, 100, 82, 0, 0, 0};
    v[7]  = '{1'b0, 100, 50, 3, 105, 52, 0, 0, 0};
    v[8]  = '{1'b1, 1010, 0, 1, 1020, 5, 1, 4266, 15};
    v[9]  = '{1'b1, 1010, 0, 1, 5, 5, 0, 0, 0};
    v[10] = '{1'b1, 0, 470, 0, 3, 479, 1, 291, 10};

    tick;
    tick;
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_ie", int'(is_enemy), 0);
    chk("rst_idx", int'(enemy_index), 0);
    chk("rst_addr", int'(spr_rom_addr), 0);
    Reset_n = 1'b1;
    tick;

    for (int k = 0; k < 11; k++) begin
      enemy_alive[0] = v[k].al;
      enemy_x[0] = 10'(v[k].x);
      enemy_y[0] = 10'(v[k].y);
      enemy_dir[0] = 2'(v[k].dir);
      fs;
      probe(v[k].dx, v[k].dy, a0, a1, ie, i0, i1, ov);
      chk($sformatf("v%0d_addr", k), a0, v[k].addr);
      chk($sformatf("v%0d_ie", k), ie, v[k].ie);
      chk($sformatf("v%0d_idx", k), i0, v[k].idx);
      chk($sformatf("v%0d_ov", k), ov, 1);
    end

    // Mid-stream reset flushes the pipeline
    enemy_alive[0] = 1'b1;
    enemy_x[0] = 10'd100;
    enemy_y[0] = 10'd50;
    enemy_dir[0] = 2'd3;
    fs;
    DrawX = 10'd105;
    DrawY = 10'd52;
    pix_valid = 1'b1;
    tick;
    tick;
    tick;
    chk("pre_rst_ov", int'(out_valid), 1);
    chk("pre_rst_idx", int'(enemy_index[0]), 7);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_ov", int'(out_valid), 0);
    chk("mid_rst_ie", int'(is_enemy), 0);
    chk("mid_rst_idx", int'(enemy_index), 0);
    chk("mid_rst_addr", int'(spr_rom_addr), 0);
    tick;
    tick;
    chk("hold_rst_ov", int'(out_valid), 0);
    pix_valid = 1'b0;
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("post_rst_ov", int'(out_valid), 0);
    end
    probe(105, 52, a0, a1, ie, i0, i1, ov);
    chk("post_rst_pix_ov", ov, 1);
    chk("post_rst_pix_ie", ie, 0);

    // Tearing: shadow only moves at frame_start
    fs;
    enemy_x[0] = 10'd300;
    probe(105, 52, a0, a1, ie, i0, i1, ov);
    chk("tear_old_ie", ie, 1);
    chk("tear_old_idx", i0, 7);
    DrawX = 10'd105;
    DrawY = 10'd52;
    pix_valid = 1'b1;
    frame_start = 1'b1;
    tick;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    tick;
    tick;
    chk("tear_coinc_ie", int'(is_enemy), 1);
    probe(105, 52, a0, a1, ie, i0, i1, ov);
    chk("tear_new_old_pos_ie", ie, 0);
    probe(305, 52, a0, a1, ie, i0, i1, ov);
    chk("tear_new_ie", ie, 1);
    chk("tear_new_addr", a0, 12357);

    // Animation stepping
    enemy_x[0] = 10'd100;
    fs;
    enemy_moving[0] = 1'b1;
    repeat (7) fs;
    probe(105, 52, a0, a1, ie, i0, i1, ov);
    chk("anim_7", a0, 12357);
    fs;
    probe(105, 52, a0, a1, ie, i0, i1, ov);
    chk("anim_8", a0, 13381);
    repeat (24) fs;
    probe(105, 52, a0, a1, ie, i0, i1, ov);
    chk("anim_32", a0, 12357);
    repeat (8) fs;
    probe(105, 52, a0, a1, ie, i0, i1, ov);
    chk("anim_40", a0, 13381);
    enemy_moving[0] = 1'b0;
    fs;
    probe(105, 52, a0, a1, ie, i0, i1, ov);
    chk("anim_stop", a0, 12357);

    // Overlapping slots report independently
    enemy_alive[1] = 1'b1;
    enemy_x[1] = 10'd110;
    enemy_y[1] = 10'd55;
    enemy_dir[1] = 2'd0;
    fs;
    probe(115, 61, a0, a1, ie, i0, i1, ov);
    chk("ovl_ie", ie, 3);
    chk("ovl_i0", i0, 4);
    chk("ovl_i1", i1, 3);
    chk("ovl_a1", a1, 197);

    enemy_hit[1] = 1'b1;
    tick;
    enemy_hit[1] = 1'b0;
`ifdef ENEMY_HIT_FLASH_EN
    probe(115, 61, a0, a1, ie, i0, i1, ov);
    chk("flash_i1", i1, 2);
    chk("flash_i0_raw", i0, 4);
    probe(115, 60, a0, a1, ie, i0, i1, ov);
    chk("flash_transp", i1, 0);
    chk("flash_transp_ie", ie, 3);
    repeat (5) fs;
    probe(115, 61, a0, a1, ie, i0, i1, ov);
    chk("flash_5", i1, 2);
    fs;
    probe(115, 61, a0, a1, ie, i0, i1, ov);
    chk("flash_6", i1, 3);
    enemy_hit[1] = 1'b1;
    tick;
    enemy_hit[1] = 1'b0;
    repeat (3) fs;
    enemy_hit[1] = 1'b1;
    frame_start = 1'b1;
    tick;
    enemy_hit[1] = 1'b0;
    frame_start = 1'b0;
    repeat (5) fs;
    probe(115, 61, a0, a1, ie, i0, i1, ov);
    chk("reload_5", i1, 2);
    fs;
    probe(115, 61, a0, a1, ie, i0, i1, ov);
    chk("reload_6", i1, 3);
`else
    probe(115, 61, a0, a1, ie, i0, i1, ov);
    chk("hit_ignored", i1, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
